eth_rx_port_arbiter: RTL

- Frame-atomic round-robin arbiter that shares the single ethernet_frame_parser AXI-Stream input among NUM_PORTS ingress sources (MAC lanes, loopback, test injector).
- Sits directly in front of the parser's s_axis port and locks a grant for a whole frame, so the parser never sees interleaved beats.
- Tags each output beat with its source index.

---
 rtl/eth_parser_pkg.sv | 12 +
 rtl/eth_rx_port_arbiter_rr_pick.sv | 31 +++
 rtl/eth_rx_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/eth_parser_pkg.sv
// Shared types for the ethernet parser front end: ingress arbiter state
// encoding and statistics counter width.
package eth_parser_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int ARB_STAT_W = 32;

endpackage : eth_parser_pkg

// File: rtl/eth_rx_port_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request after
// lastIdx_i, wrapping explicitly so non-power-of-2 N never yields an invalid index.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] lastIdx_i,
    output logic            any_o,
    output logic [ID_W-1:0] idx_o
);

    logic found;
    int   cand;

    // Scan starts one past the previous winner so it ends up lowest priority
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(lastIdx_i) + i) % N;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = ID_W'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/eth_rx_port_arbiter.sv
// Frame-atomic round-robin arbiter feeding the frame parser's single stream input.
// Optional per-port frame counters are compiled in when ARB_STATS_EN is defined.
module eth_rx_port_arbiter
    import eth_parser_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]        s_axis_tlast,
    output logic [NUM_PORTS-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [ID_W-1:0]             m_axis_tid,
    output logic                        busy
`ifdef ARB_STATS_EN
    ,
    input  logic                        stat_clear,
    output logic [NUM_PORTS*ARB_STAT_W-1:0] stat_frames
`endif
);

    arb_state_t      state_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] lastGrant_q;
    logic            busy_q;

    logic            pickAny;
    logic [ID_W-1:0] pickIdx;

    logic [DATA_W-1:0] selData;
    logic              selValid;
    logic              selLast;
    logic              locked;
    logic              frameDone;

    rr_pick #(
        .N    (NUM_PORTS),
        .ID_W (ID_W)
    ) u_pick (
        .req_i     (s_axis_tvalid),
        .lastIdx_i (lastGrant_q),
        .any_o     (pickAny),
        .idx_o     (pickIdx)
    );

    assign locked = (state_q == ARB_LOCKED);

    // Granted-port selection by comparison rather than a variable part-select,
    // so an encoding outside 0..NUM_PORTS-1 can never address a missing lane
    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selLast  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == ID_W'(p)) begin
                selData  = s_axis_tdata[p*DATA_W +: DATA_W];
                selValid = s_axis_tvalid[p];
                selLast  = s_axis_tlast[p];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s_axis_tready[p] = locked && (grant_q == ID_W'(p)) && m_axis_tready;
        end
    end

    assign m_axis_tdata  = selData;
    assign m_axis_tlast  = selLast;
    assign m_axis_tvalid = locked && selValid;
    assign m_axis_tid    = grant_q;
    assign busy          = busy_q;
    assign frameDone     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Grant is captured in IDLE and held until the tlast handshake, which
    // forces the single bubble cycle between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            lastGrant_q <= ID_W'(NUM_PORTS - 1);
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pickAny) begin
                        state_q     <= ARB_LOCKED;
                        grant_q     <= pickIdx;
                        lastGrant_q <= pickIdx;
                        busy_q      <= 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (frameDone) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [ARB_STAT_W-1:0] statCnt_q [NUM_PORTS];

    // Clear dominates a simultaneous increment; counters wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                statCnt_q[p] <= '0;
            end
        end else if (stat_clear) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                statCnt_q[p] <= '0;
            end
        end else if (frameDone) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant_q == ID_W'(p)) begin
                    statCnt_q[p] <= statCnt_q[p] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_frames = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            stat_frames[p*ARB_STAT_W +: ARB_STAT_W] = statCnt_q[p];
        end
    end
`endif

endmodule : eth_rx_port_arbiter
